// File: rtl/stack_cpu_ctrl_pkg.sv
// Shared types for the stack CPU sequencer: opcodes, sequencer states, fault codes.
// No logic; imported by the sequencer and its opcode decoder.
// The FAULT state only exists when STACKCPU_FAULT_EN is defined.
package stackCPU_DEFS;

  localparam int DATA_WIDTH_DEF  = 32;
  localparam int STACK_DEPTH_DEF = 16;
  localparam int INSTR_WIDTH_DEF = 16;
  localparam int PC_WIDTH_DEF    = 8;
  localparam int IMM_WIDTH       = 11;
  localparam int OPC_WIDTH       = 5;

  typedef enum logic [OPC_WIDTH-1:0] {
    PUSH_IMMEDIATE = 5'd0,
    ADD            = 5'd1,
    SUB            = 5'd2,
    MUL            = 5'd3,
    DIV            = 5'd4,
    MOD            = 5'd5,
    AND            = 5'd6,
    OR             = 5'd7,
    INVERT         = 5'd8,
    HALT_CPU       = 5'd31
  } opcode_t;

`ifdef STACKCPU_FAULT_EN
  typedef enum logic [2:0] {FETCH, DECODE, POP2, POP1, PUSH, HALTED, FAULT} state_t;
`else
  typedef enum logic [2:0] {FETCH, DECODE, POP2, POP1, PUSH, HALTED} state_t;
`endif

  localparam logic [1:0] ERR_UNDERFLOW = 2'b00;
  localparam logic [1:0] ERR_OVERFLOW  = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL   = 2'b10;
  localparam logic [1:0] ERR_DIV_ZERO  = 2'b11;

endpackage

// File: rtl/stack_cpu_ctrl_decode.sv
// Opcode classifier: maps an opcode to its instruction class flags.
// Latency: purely combinational.
// Backpressure: none.
module stack_cpu_decode
  import stackCPU_DEFS::*;
(
  input  opcode_t opcode,
  output logic    is_push,
  output logic    is_binary,
  output logic    is_unary,
  output logic    is_halt,
  output logic    is_divmod,
  output logic    legal
);

  // Classify the opcode; anything not listed is illegal.
  always_comb begin
    is_push   = 1'b0;
    is_binary = 1'b0;
    is_unary  = 1'b0;
    is_halt   = 1'b0;
    is_divmod = 1'b0;
    legal     = 1'b1;
    case (opcode)
      PUSH_IMMEDIATE:        is_push = 1'b1;
      ADD, SUB, MUL, AND, OR: is_binary = 1'b1;
      DIV, MOD: begin
        is_binary = 1'b1;
        is_divmod = 1'b1;
      end
      INVERT:   is_unary = 1'b1;
      HALT_CPU: is_halt  = 1'b1;
      default:  legal    = 1'b0;
    endcase
  end

endmodule

// File: rtl/stack_cpu_ctrl.sv
// Stack CPU sequencer: PC/IR owner, walks FETCH-DECODE-POP2-POP1-PUSH, drives stack strobes and ALU operands.
// Latency: 3 cycles PUSH_IMMEDIATE, 4 INVERT, 5 binary ops, 2 HALT_CPU; strobes are single-cycle pulses.
// Backpressure: none; the stack and ALU are assumed always ready. Fault checks exist only with STACKCPU_FAULT_EN.
module stack_cpu_ctrl
  import stackCPU_DEFS::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int PC_WIDTH    = PC_WIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic [PC_WIDTH-1:0]            pc,
  input  logic [INSTR_WIDTH-1:0]         instr,
  input  logic [DATA_WIDTH-1:0]          stk_top,
  input  logic [$clog2(STACK_DEPTH):0]   stk_count,
  output logic                           stk_pop,
  output logic                           stk_push,
  output logic [DATA_WIDTH-1:0]          stk_wdata,
  output opcode_t                        alu_op,
  output logic [DATA_WIDTH-1:0]          op_a,
  output logic [DATA_WIDTH-1:0]          op_b,
  input  logic [DATA_WIDTH-1:0]          alu_result,
  output logic                           halted,
  output logic                           fault,
  output logic [1:0]                     err_code
);

  localparam int CNT_W = $clog2(STACK_DEPTH) + 1;

  state_t                  state, state_nxt;
  logic [INSTR_WIDTH-1:0]  ir;
  opcode_t                 dec_opcode;
  logic                    is_push, is_binary, is_unary, is_halt, is_divmod, legal;
  logic [DATA_WIDTH-1:0]   imm_ext;

  // In DECODE the IR is not loaded yet, so classify straight from program memory.
  assign dec_opcode = opcode_t'((state == DECODE) ? instr[INSTR_WIDTH-1 -: OPC_WIDTH]
                                                  : ir[INSTR_WIDTH-1 -: OPC_WIDTH]);

  stack_cpu_decode u_decode (
    .opcode    (dec_opcode),
    .is_push   (is_push),
    .is_binary (is_binary),
    .is_unary  (is_unary),
    .is_halt   (is_halt),
    .is_divmod (is_divmod),
    .legal     (legal)
  );

  assign imm_ext   = {{(DATA_WIDTH-IMM_WIDTH){ir[IMM_WIDTH-1]}}, ir[IMM_WIDTH-1:0]};
  assign stk_wdata = is_push ? imm_ext : alu_result;

`ifdef STACKCPU_FAULT_EN
  logic [1:0] err_nxt;
`endif

  // Next-state and stack strobes.
  always_comb begin
    state_nxt = state;
    stk_pop   = 1'b0;
    stk_push  = 1'b0;
`ifdef STACKCPU_FAULT_EN
    err_nxt   = ERR_UNDERFLOW;
`endif
    case (state)
      FETCH: state_nxt = DECODE;
      DECODE: begin
        if (is_halt)        state_nxt = HALTED;
        else if (is_push)   state_nxt = PUSH;
        else if (is_binary) state_nxt = POP2;
        else if (is_unary)  state_nxt = POP1;
        else                state_nxt = FETCH;   // illegal opcode runs as a NOP
`ifdef STACKCPU_FAULT_EN
        // Faults caught here leave the stack untouched: no pops are issued.
        if (!legal) begin
          state_nxt = FAULT;
          err_nxt   = ERR_ILLEGAL;
        end else if (is_push && stk_count == CNT_W'(STACK_DEPTH)) begin
          state_nxt = FAULT;
          err_nxt   = ERR_OVERFLOW;
        end else if ((is_binary && stk_count < CNT_W'(2)) ||
                     (is_unary && stk_count == '0)) begin
          state_nxt = FAULT;
          err_nxt   = ERR_UNDERFLOW;
        end
`endif
      end
      POP2: begin
        stk_pop   = 1'b1;
        state_nxt = POP1;
      end
      POP1: begin
        stk_pop   = 1'b1;
        state_nxt = PUSH;
`ifdef STACKCPU_FAULT_EN
        // Divisor was captured in POP2; both operands are consumed, nothing is pushed.
        if (is_divmod && op_b == '0) begin
          state_nxt = FAULT;
          err_nxt   = ERR_DIV_ZERO;
        end
`endif
      end
      PUSH: begin
        stk_push  = 1'b1;
        state_nxt = FETCH;
      end
      default: state_nxt = state;   // HALTED / FAULT are terminal
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  // PC, IR, ALU opcode and operand registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= '0;
      ir     <= '0;
      alu_op <= PUSH_IMMEDIATE;
      op_a   <= '0;
      op_b   <= '0;
    end else begin
      case (state)
        DECODE: begin
          ir     <= instr;
          alu_op <= opcode_t'(instr[INSTR_WIDTH-1 -: OPC_WIDTH]);
          pc     <= pc + PC_WIDTH'(1);
        end
        POP2:    op_b <= stk_top;
        POP1:    op_a <= stk_top;
        default: ;
      endcase
    end
  end

  // Halt flag, set on entry to HALTED.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    halted <= 1'b0;
    else if (state_nxt == HALTED) halted <= 1'b1;
  end

`ifdef STACKCPU_FAULT_EN
  logic       fault_q;
  logic [1:0] err_q;

  // Fault cause captured once on entry to FAULT and held until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_q <= 1'b0;
      err_q   <= ERR_UNDERFLOW;
    end else if (state_nxt == FAULT && state != FAULT) begin
      fault_q <= 1'b1;
      err_q   <= err_nxt;
    end
  end

  assign fault    = fault_q;
  assign err_code = err_q;
`else
  logic unused_nofault;
  assign unused_nofault = ^{is_divmod, legal, stk_count};
  assign fault    = 1'b0;
  assign err_code = ERR_UNDERFLOW;
`endif

endmodule
